// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel array frame sequencer:
// state encoding, control-output bundle and default phase durations.
package pixel_ctrl_pkg;

    localparam int DUR_W = 16;

    localparam int DEF_ERASE_CYCLES    = 5;
    localparam int DEF_EXPOSE_CYCLES   = 255;
    localparam int DEF_CONVERT_CYCLES  = 255;
    localparam int DEF_NUM_ROWS        = 2;
    localparam int DEF_ROW_HOLD_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    typedef struct packed {
        logic power_enable;
        logic pixel_reset;
        logic erase;
        logic expose;
        logic write_enable;
        logic counter_reset;
        logic counter_enable;
        logic ramp_enable;
        logic read_enable;
        logic busy;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = ctrl_t'(10'd0);

    // Down-counter reload value for a phase of 'cycles' length; 0 and 1 both mean one cycle.
    function automatic logic [DUR_W-1:0] load_for(input int cycles);
        if (cycles <= 1) begin
            return {DUR_W{1'b0}};
        end else begin
            return DUR_W'(cycles - 1);
        end
    endfunction

endpackage

// File: rtl/pixel_array_controller_phase_timer.sv
// Loadable 16-bit down-counter; done is high while the count sits at zero,
// i.e. on the last cycle of the phase it was loaded for.
module phase_timer
    import pixel_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DUR_W-1:0] load_value,
    output logic [DUR_W-1:0] count,
    output logic             done
);

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {DUR_W{1'b0}};
        end else if (load) begin
            count <= load_value;
        end else if (count != {DUR_W{1'b0}}) begin
            count <= count - DUR_W'(1);
        end else begin
            count <= count;
        end
    end

    assign done = (count == {DUR_W{1'b0}});

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer: erase -> expose -> convert -> row readout, with abort,
// continuous mode and registered, state-decoded array controls.
module pixel_array_controller
    import pixel_ctrl_pkg::*;
#(
    parameter int ERASE_CYCLES    = DEF_ERASE_CYCLES,
    parameter int EXPOSE_CYCLES   = DEF_EXPOSE_CYCLES,
    parameter int CONVERT_CYCLES  = DEF_CONVERT_CYCLES,
    parameter int NUM_ROWS        = DEF_NUM_ROWS,
    parameter int ROW_HOLD_CYCLES = DEF_ROW_HOLD_CYCLES,
    localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             CONTINUOUS,
    input  logic             ABORT,
    output logic             POWER_ENABLE,
    output logic             PIXEL_RESET,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             WRITE_ENABLE,
    output logic             COUNTER_RESET,
    output logic             COUNTER_ENABLE,
    output logic             RAMP_ENABLE,
    output logic             READ_ENABLE,
    output logic [ROW_W-1:0] READ_ROW,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    if (ERASE_CYCLES > 65535 || EXPOSE_CYCLES > 65535 || CONVERT_CYCLES > 65535 ||
        ROW_HOLD_CYCLES > 65535 || NUM_ROWS < 1) begin : g_param_check
        $error("pixel_array_controller: duration above 65535 or NUM_ROWS below 1");
    end

    localparam logic [DUR_W-1:0] ERASE_LOAD   = load_for(ERASE_CYCLES);
    localparam logic [DUR_W-1:0] EXPOSE_LOAD  = load_for(EXPOSE_CYCLES);
    localparam logic [DUR_W-1:0] CONVERT_LOAD = load_for(CONVERT_CYCLES);
    localparam logic [DUR_W-1:0] HOLD_LOAD    = load_for(ROW_HOLD_CYCLES);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(NUM_ROWS - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_next_s;
    logic             load_s;
    logic [DUR_W-1:0] load_value_s;
    logic [DUR_W-1:0] count_s;
    logic             done_s;
    logic             count_next_zero_s;
    logic             frame_done_next_s;
    ctrl_t            ctrl_next_s;
    ctrl_t            ctrl_r;
    logic             frame_done_r;

    phase_timer u_phase_timer (
        .clk        (CLOCK),
        .rst        (RESET),
        .load       (load_s),
        .load_value (load_value_s),
        .count      (count_s),
        .done       (done_s)
    );

    // Next state, row index and timer reload; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        row_next_s   = row_r;
        load_s       = 1'b0;
        load_value_s = {DUR_W{1'b0}};
        if (ABORT) begin
            state_next_s = ST_IDLE;
            row_next_s   = {ROW_W{1'b0}};
            load_s       = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_next_s = ST_ERASE;
                        load_s       = 1'b1;
                        load_value_s = ERASE_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ERASE: begin
                    if (done_s) begin
                        state_next_s = ST_EXPOSE;
                        load_s       = 1'b1;
                        load_value_s = EXPOSE_LOAD;
                    end else begin
                        state_next_s = ST_ERASE;
                    end
                end
                ST_EXPOSE: begin
                    if (done_s) begin
                        state_next_s = ST_CONVERT;
                        load_s       = 1'b1;
                        load_value_s = CONVERT_LOAD;
                    end else begin
                        state_next_s = ST_EXPOSE;
                    end
                end
                ST_CONVERT: begin
                    if (done_s) begin
                        state_next_s = ST_READ;
                        row_next_s   = {ROW_W{1'b0}};
                        load_s       = 1'b1;
                        load_value_s = HOLD_LOAD;
                    end else begin
                        state_next_s = ST_CONVERT;
                    end
                end
                ST_READ: begin
                    if (done_s && (row_r == LAST_ROW)) begin
                        row_next_s = {ROW_W{1'b0}};
                        load_s     = 1'b1;
                        if (CONTINUOUS) begin
                            state_next_s = ST_ERASE;
                            load_value_s = ERASE_LOAD;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else if (done_s) begin
                        row_next_s   = row_r + ROW_W'(1);
                        load_s       = 1'b1;
                        load_value_s = HOLD_LOAD;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    row_next_s   = {ROW_W{1'b0}};
                    load_s       = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so look ahead one cycle for the last READ cycle.
    always_comb begin
        count_next_zero_s = load_s ? (load_value_s == {DUR_W{1'b0}}) : (count_s <= DUR_W'(1));
        frame_done_next_s = (state_next_s == ST_READ) && (row_next_s == LAST_ROW) && count_next_zero_s;
    end

    // Control decode of the state the block is about to enter.
    always_comb begin
        ctrl_next_s = CTRL_OFF;
        case (state_next_s)
            ST_IDLE: begin
                ctrl_next_s.counter_reset = 1'b1;
            end
            ST_ERASE: begin
                ctrl_next_s.power_enable  = 1'b1;
                ctrl_next_s.pixel_reset   = 1'b1;
                ctrl_next_s.erase         = 1'b1;
                ctrl_next_s.counter_reset = 1'b1;
                ctrl_next_s.busy          = 1'b1;
            end
            ST_EXPOSE: begin
                ctrl_next_s.power_enable  = 1'b1;
                ctrl_next_s.expose        = 1'b1;
                ctrl_next_s.counter_reset = 1'b1;
                ctrl_next_s.busy          = 1'b1;
            end
            ST_CONVERT: begin
                ctrl_next_s.power_enable   = 1'b1;
                ctrl_next_s.write_enable   = 1'b1;
                ctrl_next_s.counter_enable = 1'b1;
                ctrl_next_s.ramp_enable    = 1'b1;
                ctrl_next_s.busy           = 1'b1;
            end
            ST_READ: begin
                ctrl_next_s.read_enable   = 1'b1;
                ctrl_next_s.counter_reset = 1'b1;
                ctrl_next_s.busy          = 1'b1;
            end
            default: begin
                ctrl_next_s.counter_reset = 1'b1;
            end
        endcase
    end

    // State, row and output registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r                <= ST_IDLE;
            row_r                  <= {ROW_W{1'b0}};
            ctrl_r                 <= CTRL_OFF;
            ctrl_r.counter_reset   <= 1'b1;
            frame_done_r           <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            row_r        <= row_next_s;
            ctrl_r       <= ctrl_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    assign POWER_ENABLE   = ctrl_r.power_enable;
    assign PIXEL_RESET    = ctrl_r.pixel_reset;
    assign ERASE          = ctrl_r.erase;
    assign EXPOSE         = ctrl_r.expose;
    assign WRITE_ENABLE   = ctrl_r.write_enable;
    assign COUNTER_RESET  = ctrl_r.counter_reset;
    assign COUNTER_ENABLE = ctrl_r.counter_enable;
    assign RAMP_ENABLE    = ctrl_r.ramp_enable;
    assign READ_ENABLE    = ctrl_r.read_enable;
    assign BUSY           = ctrl_r.busy;
    assign READ_ROW       = row_r;
    assign FRAME_DONE     = frame_done_r;

endmodule

// File: tb/tb_pixel_array_controller.sv
// Directed bench: default-parameter instance for frame, continuous, abort and
// async-reset sequences; a degenerate-parameter instance for minimum phase lengths.
module tb_pixel_array_controller;

    // {POWER, PIXRST, ERASE, EXPOSE, WE, CNTRST, CNTEN, RAMP, RDEN, BUSY, FDONE}
    localparam logic [10:0] V_IDLE    = 11'b00000100000;
    localparam logic [10:0] V_ERASE   = 11'b11100100010;
    localparam logic [10:0] V_EXPOSE  = 11'b10010100010;
    localparam logic [10:0] V_CONVERT = 11'b10001011010;
    localparam logic [10:0] V_READ    = 11'b00000100110;
    localparam logic [10:0] V_READ_FD = 11'b00000100111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cont, abort;
    logic pe1, pr1, er1, ex1, we1, cr1, ce1, re1, rd1, busy1, fd1;
    logic [0:0] row1;
    logic rst2, start2, cont2, abort2;
    logic pe2, pr2, er2, ex2, we2, cr2, ce2, re2, rd2, busy2, fd2;
    logic [0:0] row2;
    logic [10:0] outs1, outs2;

    int total = 0;
    int bad = 0;

    assign outs1 = {pe1, pr1, er1, ex1, we1, cr1, ce1, re1, rd1, busy1, fd1};
    assign outs2 = {pe2, pr2, er2, ex2, we2, cr2, ce2, re2, rd2, busy2, fd2};

    pixel_array_controller dut1 (
        .CLOCK(clk), .RESET(rst), .START(start), .CONTINUOUS(cont), .ABORT(abort),
        .POWER_ENABLE(pe1), .PIXEL_RESET(pr1), .ERASE(er1), .EXPOSE(ex1),
        .WRITE_ENABLE(we1), .COUNTER_RESET(cr1), .COUNTER_ENABLE(ce1),
        .RAMP_ENABLE(re1), .READ_ENABLE(rd1), .READ_ROW(row1), .BUSY(busy1),
        .FRAME_DONE(fd1)
    );

    pixel_array_controller #(
        .ERASE_CYCLES(0), .EXPOSE_CYCLES(3), .CONVERT_CYCLES(2),
        .NUM_ROWS(1), .ROW_HOLD_CYCLES(0)
    ) dut2 (
        .CLOCK(clk), .RESET(rst2), .START(start2), .CONTINUOUS(cont2), .ABORT(abort2),
        .POWER_ENABLE(pe2), .PIXEL_RESET(pr2), .ERASE(er2), .EXPOSE(ex2),
        .WRITE_ENABLE(we2), .COUNTER_RESET(cr2), .COUNTER_ENABLE(ce2),
        .RAMP_ENABLE(re2), .READ_ENABLE(rd2), .READ_ROW(row2), .BUSY(busy2),
        .FRAME_DONE(fd2)
    );

    // Expected control vector for frame cycle c (1 = first ERASE cycle).
    function automatic logic [10:0] exp_vec(input int c, input int e, input int x,
                                            input int cv, input int rows, input int hold);
        int r;
        r = c;
        if (r < 1) return V_IDLE;
        if (r <= e) return V_ERASE;
        r = r - e;
        if (r <= x) return V_EXPOSE;
        r = r - x;
        if (r <= cv) return V_CONVERT;
        r = r - cv;
        if (r < rows * hold) return V_READ;
        if (r == rows * hold) return V_READ_FD;
        return V_IDLE;
    endfunction

    // Expected READ_ROW during readout, -1 outside readout.
    function automatic int exp_row(input int c, input int pre, input int rows, input int hold);
        int r;
        r = c - pre;
        if (r >= 1 && r <= rows * hold) return (r - 1) / hold;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check one cycle of a default-parameter frame on dut1.
    task automatic check_frame1(input string tag, input int c);
        int er;
        check($sformatf("%s c=%0d", tag, c), {21'd0, outs1}, {21'd0, exp_vec(c, 5, 255, 255, 2, 2)});
        er = exp_row(c, 515, 2, 2);
        if (er >= 0) check($sformatf("%s row c=%0d", tag, c), {31'd0, row1}, er);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; cont2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vec", {21'd0, outs1}, {21'd0, V_IDLE});
        check("reset_row", {31'd0, row1}, 32'd0);
        rst = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle i=%0d", i), {21'd0, outs1}, {21'd0, V_IDLE});
        end
        check("idle_row", {31'd0, row1}, 32'd0);

        // single frame, START for one cycle
        start = 1'b1;
        for (int c = 1; c <= 525; c++) begin
            step();
            if (c == 1) start = 1'b0;
            check_frame1("single", c);
        end

        // continuous: second ERASE directly after first FRAME_DONE
        cont = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 1045; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 600) cont = 1'b0;
            check_frame1("cont", (c <= 519) ? c : c - 519);
        end

        // abort in CONVERT at cycle 300 with START held
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (c == 1) start = 1'b0;
            check_frame1("pre_abort", c);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        check("abort_idle", {21'd0, outs1}, {21'd0, V_IDLE});
        abort = 1'b0;
        step();
        check("restart_erase", {21'd0, outs1}, {21'd0, V_ERASE});
        start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            step();
            check_frame1("restart", c);
        end
        abort = 1'b1;
        step();
        check("abort_expose", {21'd0, outs1}, {21'd0, V_IDLE});
        abort = 1'b0;
        step();
        check("abort_stays_idle", {21'd0, outs1}, {21'd0, V_IDLE});

        // degenerate parameters on dut2: ERASE 1, EXPOSE 3, CONVERT 2, one READ cycle
        check("dut2_idle", {21'd0, outs2}, {21'd0, V_IDLE});
        start2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) start2 = 1'b0;
            check($sformatf("degen c=%0d", c), {21'd0, outs2}, {21'd0, exp_vec(c, 1, 3, 2, 1, 1)});
            check($sformatf("degen row c=%0d", c), {31'd0, row2}, 32'd0);
        end

        // asynchronous reset mid-EXPOSE, between clock edges
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (c == 1) start = 1'b0;
            check_frame1("pre_rst", c);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vec", {21'd0, outs1}, {21'd0, V_IDLE});
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_idle", {21'd0, outs1}, {21'd0, V_IDLE});
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) start = 1'b0;
            check_frame1("post_rst", c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
